// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing, framebuffer prefetch into a line FIFO, and
// 16-bit pixel to 24-bit RGB expansion with integer scaling.
// Ports: i_clk, i_reset (sync, active high); i_display_offset, i_mode
// (frame base / RGB555 select, latched at frame start); o_rd_req,
// o_rd_addr, i_rd_ack, i_rd_valid, i_rd_data (in-order memory reads);
// i_underflow_clr, o_underflow (sticky starvation flag);
// o_vga_r/g/b, o_vga_blank_n, o_vga_sync_n, o_vga_hs, o_vga_vs (DAC pins).
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int ADDR_W      = 18,
    parameter int FB_WIDTH    = 320,
    parameter int SCALE_SHIFT = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_display_offset,
    input  logic              i_mode,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_ack,
    input  logic              i_rd_valid,
    input  logic [15:0]       i_rd_data,
    input  logic              i_underflow_clr,
    output logic              o_underflow,
    output logic [7:0]        o_vga_r,
    output logic [7:0]        o_vga_g,
    output logic [7:0]        o_vga_b,
    output logic              o_vga_blank_n,
    output logic              o_vga_sync_n,
    output logic              o_vga_hs,
    output logic              o_vga_vs
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WW      = $clog2(FB_WIDTH + 1);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int SMASK   = (1 << SCALE_SHIFT) - 1;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int VS_BEG  = V_ACTIVE + V_FP;

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              mode_q, mode_d;
    logic [WW-1:0]     word_q, word_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic              underflow_q, underflow_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              blank_q, blank_d;
    logic              hs_q, hs_d, vs_q, vs_d;

    int                hi, vi, ti;
    logic [VW-1:0]     t_line;
    logic [CW:0]       occ;
    logic              line_start, visible, ack, push, pop, starve;
    logic [15:0]       head;
    logic [7:0]        ex_r, ex_g, ex_b;

    assign hi = int'(h_q);
    assign vi = int'(v_q);
    // Line being prepared at the line-start event.
    assign t_line = (vi == V_TOTAL - 1) ? '0 : v_q + 1'b1;
    assign ti = int'(t_line);

    assign line_start = (hi == H_ACTIVE);
    assign visible = (hi < H_ACTIVE) && (vi < V_ACTIVE);
    assign starve = visible && (count_q == '0);
    // Pop after the last replicated copy of the head word.
    assign pop = visible && (count_q != '0)
               && ((h_q & HW'(SMASK)) == HW'(SMASK));
    // Words landing on a line start belong to the old line.
    assign push = i_rd_valid && (drop_q == '0) && !line_start;

    // FIFO space is reserved at request time so pushes never overflow.
    assign occ = {1'b0, count_q} + {1'b0, inflight_q};
    assign o_rd_req = (word_q < WW'(FB_WIDTH))
                    && (occ < (CW+1)'(FIFO_DEPTH));
    assign o_rd_addr = offset_q + row_base_q + ADDR_W'(word_q);
    assign ack = o_rd_req && i_rd_ack;

    assign head = mem_q[rptr_q];

    always_comb begin
        ex_b = {head[4:0], head[4:2]};
        if (mode_q) begin
            ex_r = {head[14:10], head[14:12]};
            ex_g = {head[9:5], head[9:7]};
        end else begin
            ex_r = {head[15:11], head[15:13]};
            ex_g = {head[10:5], head[10:9]};
        end
    end

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (hi == H_TOTAL - 1) begin
            h_d = '0;
            v_d = t_line;
        end

        offset_d   = offset_q;
        mode_d     = mode_q;
        row_base_d = row_base_q;
        word_d     = word_q + WW'(ack);
        inflight_d = inflight_q + CW'(ack) - CW'(i_rd_valid);
        drop_d     = drop_q;
        if (i_rd_valid && (drop_q != '0))
            drop_d = drop_q - 1'b1;
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);

        if (line_start) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            // Everything still owed by memory, including an ack taken now.
            drop_d  = inflight_d;
            word_d  = (ti < V_ACTIVE) ? '0 : WW'(FB_WIDTH);
            if (ti == 0) begin
                offset_d   = i_display_offset;
                mode_d     = i_mode;
                row_base_d = '0;
            end else if ((t_line & VW'(SMASK)) == '0) begin
                row_base_d = row_base_q + ADDR_W'(FB_WIDTH);
            end
        end

        underflow_d = underflow_q;
        if (starve)
            underflow_d = 1'b1;
        else if (i_underflow_clr)
            underflow_d = 1'b0;

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (visible && !starve) begin
            r_d = ex_r;
            g_d = ex_g;
            b_d = ex_b;
        end
        blank_d = visible;
        hs_d = (hi >= HS_BEG && hi < HS_BEG + H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d = (vi >= VS_BEG && vi < VS_BEG + V_SYNC) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            h_q         <= HW'(H_ACTIVE);
            v_q         <= VW'(V_TOTAL - 1);
            offset_q    <= '0;
            mode_q      <= 1'b0;
            row_base_q  <= '0;
            word_q      <= WW'(FB_WIDTH);
            inflight_q  <= '0;
            drop_q      <= '0;
            count_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            underflow_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            blank_q     <= 1'b0;
            hs_q        <= ~SYNC_POL;
            vs_q        <= ~SYNC_POL;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            offset_q    <= offset_d;
            mode_q      <= mode_d;
            row_base_q  <= row_base_d;
            word_q      <= word_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            underflow_q <= underflow_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            blank_q     <= blank_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wptr_q] <= i_rd_data;
    end

    assign o_underflow   = underflow_q;
    assign o_vga_r       = r_q;
    assign o_vga_g       = g_q;
    assign o_vga_b       = b_q;
    assign o_vga_blank_n = blank_q;
    assign o_vga_sync_n  = 1'b0;
    assign o_vga_hs      = hs_q;
    assign o_vga_vs      = vs_q;
endmodule
